// File: rtl/riscv_uar_pkg.sv
// rtl/riscv_uar_pkg.sv - shared types and constants for the riscv_uar receiver
//
// Purpose : receiver FSM state encoding and FIFO depth, imported by the
//           top level and by the optional FIFO sub-module.
// Ports   : none (package).
package riscv_uar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uarState_t;

  localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/riscv_uar_fifo.sv
// rtl/riscv_uar_fifo.sv - receive-byte FIFO used when RISCV_UAR_FIFO_EN is defined
//
// Purpose : FIFO_DEPTH-entry byte queue between the receiver and the consumer.
//           A push on a full queue is dropped and reported on overrun, unless
//           a pop happens in the same cycle, in which case both proceed.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           push, pushData - completed byte from the receiver
//           pop            - consumer accepts the head entry
//           popData        - oldest entry (head)
//           notEmpty       - at least one byte held
//           overrun        - one-cycle pulse, a pushed byte was dropped
module riscv_uar_fifo
  import riscv_uar_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] pushData,
  input  logic       pop,
  output logic [7:0] popData,
  output logic       notEmpty,
  output logic       overrun
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic          full;
  logic          doPop;
  logic          doPush;

  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign notEmpty = (count != '0);
  assign doPop    = pop && notEmpty;
  // A pop frees the slot in the same cycle, so a push on full still lands.
  assign doPush   = push && (!full || doPop);
  assign popData  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      overrun <= push && !doPush;
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_uar.sv
// rtl/riscv_uar.sv - 8N1 serial receiver with ready/valid byte output
//
// Purpose : oversampling UART receiver. rx is synchronised, the start edge is
//           qualified at mid start bit, data bits are sampled at mid bit (LSB
//           first) and the byte is committed at mid stop bit.
// Config  : RISCV_UAR_FIFO_EN defined   -> 4-entry FIFO (riscv_uar_fifo)
//           RISCV_UAR_FIFO_EN undefined -> single holding register
// Ports   : clk        - sole clock
//           rst        - synchronous active-high reset
//           rx         - asynchronous serial line, idle high
//           dOut       - received byte (oldest unconsumed)
//           dOutValid  - dOut holds an unconsumed byte
//           dOutReady  - consumer accepts dOut when dOutValid && dOutReady
//           frameErr   - one-cycle pulse, stop bit sampled low
//           overrun    - one-cycle pulse, completed byte dropped (storage full)
module riscv_uar
  import riscv_uar_pkg::*;
#(
  parameter int CLK_RATE = 500_000_000,
  parameter int BAUD     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dOut,
  output logic       dOutValid,
  input  logic       dOutReady,
  output logic       frameErr,
  output logic       overrun
);

  localparam int DIV = CLK_RATE / BAUD;
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] HALF_LOAD = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(DIV - 1);

  if (DIV < 4) begin : gBadDiv
    $error("riscv_uar: CLK_RATE/BAUD must be at least 4");
  end

  // Synchroniser; both flops reset high so reset looks like an idle line.
  logic rxMeta;
  logic rxS;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
    end
  end

  // The reset value of the synchroniser is not a real observation of the
  // line, so a start edge is only honoured once rxS has been high after the
  // synchroniser has refilled from rx. This keeps a line held low through
  // reset from being decoded as a frame.
  logic [1:0] flushCnt;
  logic       armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      flushCnt <= '0;
      armed    <= 1'b0;
    end else begin
      if (flushCnt != 2'd2) begin
        flushCnt <= flushCnt + 2'd1;
      end else if (rxS) begin
        armed <= 1'b1;
      end
    end
  end

  // Receiver FSM
  uarState_t     state,    stateNext;
  logic [TW-1:0] timer,    timerNext;
  logic [2:0]    bitIdx,   idxNext;
  logic [7:0]    rxData,   dataNext;
  logic          stopWait, waitNext;
  logic          commit;
  logic          ferrHit;
  logic          timerDone;

  assign timerDone = (timer == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bitIdx   <= '0;
      rxData   <= '0;
      stopWait <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      state    <= stateNext;
      timer    <= timerNext;
      bitIdx   <= idxNext;
      rxData   <= dataNext;
      stopWait <= waitNext;
      frameErr <= ferrHit;
    end
  end

  always_comb begin
    stateNext = state;
    timerNext = timer;
    idxNext   = bitIdx;
    dataNext  = rxData;
    waitNext  = stopWait;
    commit    = 1'b0;
    ferrHit   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rxS) begin
          timerNext = HALF_LOAD;
          stateNext = START;
        end
      end
      START: begin
        if (timerDone) begin
          if (!rxS) begin
            timerNext = FULL_LOAD;
            idxNext   = '0;
            stateNext = DATA;
          end else begin
            // Line went back high before mid start bit: a glitch.
            stateNext = IDLE;
          end
        end else begin
          timerNext = timer - TW'(1);
        end
      end
      DATA: begin
        if (timerDone) begin
          dataNext[bitIdx] = rxS;
          timerNext        = FULL_LOAD;
          idxNext          = bitIdx + 3'd1;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
          end
        end else begin
          timerNext = timer - TW'(1);
        end
      end
      STOP: begin
        if (stopWait) begin
          // After a framing error, hold off until the line is idle again.
          if (rxS) begin
            waitNext  = 1'b0;
            stateNext = IDLE;
          end
        end else if (timerDone) begin
          if (rxS) begin
            commit    = 1'b1;
            stateNext = IDLE;
          end else begin
            ferrHit  = 1'b1;
            waitNext = 1'b1;
          end
        end else begin
          timerNext = timer - TW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Byte storage
`ifdef RISCV_UAR_FIFO_EN
  riscv_uar_fifo uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (commit),
    .pushData (rxData),
    .pop      (dOutReady),
    .popData  (dOut),
    .notEmpty (dOutValid),
    .overrun  (overrun)
  );
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      dOut      <= '0;
      dOutValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        // An accept in the commit cycle empties the register for the new byte.
        if (!dOutValid || dOutReady) begin
          dOut      <= rxData;
          dOutValid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dOutReady) begin
        dOutValid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_uar.sv
// tb/tb_riscv_uar.sv - self-checking bench for riscv_uar
module tb_riscv_uar;

  localparam int DIV = 10;
`ifdef RISCV_UAR_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       dOutReady;
  logic [7:0] dOut;
  logic       dOutValid;
  logic       frameErr;
  logic       overrun;

  always #5 clk = ~clk;

  riscv_uar dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .dOut      (dOut),
    .dOutValid (dOutValid),
    .dOutReady (dOutReady),
    .frameErr  (frameErr),
    .overrun   (overrun)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: bytes the DUT must still deliver, plus expected error pulse counts.
  logic [7:0] model[$];
  int expFerr, expOvr, obsFerr, obsOvr;
  int validCycles, firstValidCyc, startCyc;
  logic [7:0] lastAccepted;
  logic       prevHold;
  logic [7:0] prevDout;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every accepted byte must be the model's oldest byte,
  // and a held byte must not change.
  always @(negedge clk) begin
    if (rst) begin
      prevHold = 1'b0;
    end else begin
      if (frameErr) obsFerr++;
      if (overrun)  obsOvr++;
      if (dOutValid) begin
        validCycles++;
        if (firstValidCyc < 0) firstValidCyc = cyc;
      end
      if (dOutValid && dOutReady) begin
        if (model.size() == 0) begin
          check("unexpected_byte", int'(dOut), -1);
        end else begin
          check("byte", int'(dOut), int'(model.pop_front()));
          lastAccepted = dOut;
        end
      end
      if (prevHold) check("hold_stable", int'(dOut), int'(prevDout));
      prevHold = dOutValid && !dOutReady;
      prevDout = dOut;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic modelFrame(input logic [7:0] b, input logic stopBit);
    if (!stopBit)               expFerr++;
    else if (model.size() >= CAP) expOvr++;
    else                        model.push_back(b);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    startCyc = cyc;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
    modelFrame(b, stopBit);
    rx = stopBit;
    tick(DIV);
  endtask

  task automatic clearObs();
    obsFerr = 0; obsOvr = 0; expFerr = 0; expOvr = 0;
    validCycles = 0; firstValidCyc = -1;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (model.size() != 0 && n < 40 * DIV) begin
      tick(1);
      n++;
    end
    if (model.size() != 0) check({name, "_drain_timeout"}, model.size(), 0);
    tick(DIV);
  endtask

  task automatic checkCounts(input string name);
    check({name, "_frameErr_count"}, obsFerr, expFerr);
    check({name, "_overrun_count"}, obsOvr, expOvr);
    check({name, "_pending"}, model.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx = 1'b1; dOutReady = 1'b1;
    clearObs();
    lastAccepted = 8'h00;
    prevHold = 1'b0; prevDout = 8'h00;
    tick(4);
    check("reset_dOut", int'(dOut), 0);
    check("reset_dOutValid", int'(dOutValid), 0);
    check("reset_frameErr", int'(frameErr), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick(5);

    // Single clean frame, consumer always ready
    clearObs();
    sendFrame(8'hA5, 1'b1);
    rx = 1'b1;
    tick(2 * DIV);
    check("a5_value", int'(lastAccepted), 8'hA5);
    check("a5_valid_cycles", validCycles, 1);
    check("a5_latency_ok", int'((firstValidCyc - startCyc) >= 97 && (firstValidCyc - startCyc) <= 99), 1);
    checkCounts("a5");

    // Half-bit low glitch
    clearObs();
    rx = 1'b0;
    tick(DIV / 2);
    rx = 1'b1;
    tick(3 * DIV);
    check("glitch_valid_cycles", validCycles, 0);
    checkCounts("glitch");

    // Framing error, line held low well past the stop bit
    clearObs();
    sendFrame(8'h3C, 1'b0);
    tick(3 * DIV);
    rx = 1'b1;
    tick(2 * DIV);
    check("ferr_pulses", obsFerr, 1);
    check("ferr_valid_cycles", validCycles, 0);
    checkCounts("ferr");

    // Two back-to-back frames with no consumer
    clearObs();
    dOutReady = 1'b0;
    sendFrame(8'h11, 1'b1);
    sendFrame(8'h22, 1'b1);
    rx = 1'b1;
    tick(DIV);
    check("b2b_head", int'(dOut), 8'h11);
    check("b2b_overrun", obsOvr, (CAP == 1) ? 1 : 0);
    dOutReady = 1'b1;
    waitDrain("b2b");
    checkCounts("b2b");

    // Five frames with no consumer
    clearObs();
    dOutReady = 1'b0;
    for (int k = 1; k <= 5; k++) sendFrame(8'(k), 1'b1);
    rx = 1'b1;
    tick(DIV);
    check("five_overrun", obsOvr, (CAP == 4) ? 1 : 4);
    dOutReady = 1'b1;
    waitDrain("five");
    checkCounts("five");

    // Reset during data bit 3 of 0xFF, then a clean 0x5A
    clearObs();
    rx = 1'b0;
    tick(DIV);
    rx = 1'b1;
    tick(3 * DIV + DIV / 2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5 * DIV);
    sendFrame(8'h5A, 1'b1);
    rx = 1'b1;
    tick(2 * DIV);
    check("rst_value", int'(lastAccepted), 8'h5A);
    check("rst_valid_cycles", validCycles, 1);
    checkCounts("rst");

    // Line held low through and after reset must not be decoded
    clearObs();
    rx = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(12 * DIV);
    rx = 1'b1;
    tick(2 * DIV);
    check("lowrst_valid_cycles", validCycles, 0);
    checkCounts("lowrst");
    sendFrame(8'h96, 1'b1);
    rx = 1'b1;
    tick(2 * DIV);
    check("lowrst_recover", int'(lastAccepted), 8'h96);
    checkCounts("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
